// File: rtl/reg_writeback.sv
// Register-file writer: merges execute and memory-stage results into an in-order
// queue, retires one write per cycle, and maintains the LC-3b N/Z/P condition codes.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ex_valid,
    input  logic [2:0]       ex_dr,
    input  logic [WIDTH-1:0] ex_data,
    input  logic             ex_set_cc,
    output logic             ex_ready,

    input  logic             mem_valid,
    input  logic [2:0]       mem_dr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_set_cc,
    output logic             mem_ready,

    output logic             rf_we,
    output logic [2:0]       rf_dr,
    output logic [WIDTH-1:0] rf_data,

    output logic             cc_n,
    output logic             cc_z,
    output logic             cc_p,

    output logic [7:0]       pending
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [2:0]       dr_q     [DEPTH];
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [DEPTH-1:0] setcc_q;

    ptr_t head;
    ptr_t tail;
    cnt_t count;
    cnt_t free_slots;

    logic mem_acc;
    logic ex_acc;
    logic pop;
    ptr_t ex_slot;

    logic             head_cc;
    logic [WIDTH-1:0] head_data;

    // Credit is based on registered count only; a same-cycle pop does not free a slot.
    assign free_slots = cnt_t'(DEPTH) - count;
    assign mem_ready  = (free_slots >= cnt_t'(1));
    assign ex_ready   = mem_valid ? (free_slots >= cnt_t'(2)) : (free_slots >= cnt_t'(1));

    assign mem_acc = mem_valid & mem_ready;
    assign ex_acc  = ex_valid & ex_ready;

    // Memory stage holds the older instruction, so it always takes the tail slot.
    assign ex_slot = tail + ptr_t'(mem_acc);

    assign head_data = data_q[head];
    assign head_cc   = setcc_q[head];

    assign rf_we   = (count != '0) & ~rst;
    assign rf_dr   = dr_q[head];
    assign rf_data = head_data;
    assign pop     = rf_we;

    always_ff @(posedge clk) begin
        if (mem_acc) begin
            dr_q[tail]    <= mem_dr;
            data_q[tail]  <= mem_data;
            setcc_q[tail] <= mem_set_cc;
        end
        if (ex_acc) begin
            dr_q[ex_slot]    <= ex_dr;
            data_q[ex_slot]  <= ex_data;
            setcc_q[ex_slot] <= ex_set_cc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            cc_n  <= 1'b0;
            cc_z  <= 1'b1;
            cc_p  <= 1'b0;
        end else begin
            head  <= head + ptr_t'(pop);
            tail  <= tail + ptr_t'(mem_acc) + ptr_t'(ex_acc);
            count <= count + cnt_t'(mem_acc) + cnt_t'(ex_acc) - cnt_t'(pop);
            if (pop && head_cc) begin
                cc_n <= head_data[WIDTH-1];
                cc_z <= (head_data == '0);
                cc_p <= ~head_data[WIDTH-1] & (head_data != '0);
            end
        end
    end

    // Walk the occupied slots starting at head; duplicates keep the bit set.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cnt_t'(i) < count) begin
                pending[dr_q[head + ptr_t'(i)]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: a hand-derived vector table for the directed cases, then
// randomized traffic compared against a queue-based reference model.
module tb_reg_writeback;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ex_valid, ex_set_cc, mem_valid, mem_set_cc;
    logic [2:0]  ex_dr, mem_dr;
    logic [15:0] ex_data, mem_data;
    logic        ex_ready, mem_ready, rf_we, cc_n, cc_z, cc_p;
    logic [2:0]  rf_dr;
    logic [15:0] rf_data;
    logic [7:0]  pending;

    reg_writeback #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_dr(ex_dr), .ex_data(ex_data), .ex_set_cc(ex_set_cc), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_dr(mem_dr), .mem_data(mem_data), .mem_set_cc(mem_set_cc), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data),
        .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p), .pending(pending)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file as seen through the DUT write port.
    logic [15:0] shadow [8];
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (rf_we === 1'b1) begin
            shadow[rf_dr] <= rf_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model: an ordered list of pending writes plus the flags.
    typedef struct packed {
        logic [2:0]  dr;
        logic [15:0] data;
        logic        cc;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] mcc;
    logic       last_exr, last_memr;

    function automatic logic [2:0] flags_of(input logic [15:0] d);
        if (d == 16'h0) return 3'b010;
        if (d[15])      return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_step();
        int   fr;
        logic macc, eacc;
        ent_t e;
        if (rst) begin
            mq.delete();
            mcc = 3'b010;
        end else begin
            fr   = DEPTH - mq.size();
            macc = mem_valid && (fr >= 1);
            eacc = ex_valid && (mem_valid ? (fr >= 2) : (fr >= 1));
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.cc) mcc = flags_of(e.data);
            end
            if (macc) mq.push_back('{dr: mem_dr, data: mem_data, cc: mem_set_cc});
            if (eacc) mq.push_back('{dr: ex_dr, data: ex_data, cc: ex_set_cc});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        int         fr;
        logic       xwe;
        logic [7:0] xp;
        fr        = DEPTH - mq.size();
        last_memr = (fr >= 1);
        last_exr  = mem_valid ? (fr >= 2) : (fr >= 1);
        xwe       = (mq.size() != 0) && !rst;
        xp        = '0;
        foreach (mq[k]) xp[mq[k].dr] = 1'b1;
        chk({tag, " mem_ready"}, mem_ready, last_memr);
        chk({tag, " ex_ready"}, ex_ready, last_exr);
        chk({tag, " rf_we"}, rf_we, xwe);
        if (xwe) begin
            chk({tag, " rf_dr"}, rf_dr, mq[0].dr);
            chk({tag, " rf_data"}, rf_data, mq[0].data);
        end
        chk({tag, " pending"}, pending, xp);
        chk({tag, " cc"}, {cc_n, cc_z, cc_p}, mcc);
    endtask

    typedef struct {
        logic        rst;
        logic        mv;  logic [2:0] mdr; logic [15:0] mdata; logic mcc;
        logic        ev;  logic [2:0] edr; logic [15:0] edata; logic ecc;
        logic        x_exr, x_memr, x_we;
        logic [2:0]  x_dr;
        logic [15:0] x_data;
        logic [7:0]  x_pend;
        logic [2:0]  x_cc;
    } vec_t;

    function automatic vec_t mk(
        input logic r,
        input logic mv, input logic [2:0] mdr, input logic [15:0] md, input logic mc,
        input logic ev, input logic [2:0] edr, input logic [15:0] ed, input logic ec,
        input logic xexr, input logic xmemr, input logic xwe, input logic [2:0] xdr,
        input logic [15:0] xdata, input logic [7:0] xpend, input logic [2:0] xcc);
        vec_t v;
        v.rst = r;
        v.mv = mv; v.mdr = mdr; v.mdata = md; v.mcc = mc;
        v.ev = ev; v.edr = edr; v.edata = ed; v.ecc = ec;
        v.x_exr = xexr; v.x_memr = xmemr; v.x_we = xwe; v.x_dr = xdr;
        v.x_data = xdata; v.x_pend = xpend; v.x_cc = xcc;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst;
        mem_valid = v.mv; mem_dr = v.mdr; mem_data = v.mdata; mem_set_cc = v.mcc;
        ex_valid  = v.ev; ex_dr  = v.edr; ex_data  = v.edata; ex_set_cc  = v.ecc;
    endtask

    vec_t tbl[25];
    int   wr_snap;

    initial begin
        // cc encoding is {n,z,p}
        //             rst mv mdr mdata    mc ev edr edata    ec  exr memr we dr  data     pend   cc
        tbl[0]  = mk(0, 0, 0, 16'h0000, 0, 1, 3, 16'h0005, 1,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b010);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 3, 16'h0005, 8'h08, 3'b010);
        tbl[2]  = mk(0, 1, 1, 16'h8000, 1, 1, 2, 16'h0000, 1,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 1, 16'h8000, 8'h06, 3'b001);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 2, 16'h0000, 8'h04, 3'b100);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 1, 4, 16'h0001, 1,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b010);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 1, 6, 16'hFFFF, 0,  1, 1, 1, 4, 16'h0001, 8'h10, 3'b010);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 6, 16'hFFFF, 8'h40, 3'b001);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[9]  = mk(0, 1, 5, 16'h1111, 0, 1, 5, 16'h2222, 0,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[10] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 5, 16'h1111, 8'h20, 3'b001);
        tbl[11] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 5, 16'h2222, 8'h20, 3'b001);
        tbl[12] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[13] = mk(0, 1, 0, 16'h000A, 0, 1, 7, 16'h000B, 0,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[14] = mk(0, 1, 1, 16'h000C, 0, 1, 2, 16'h000D, 0,  1, 1, 1, 0, 16'h000A, 8'h81, 3'b001);
        tbl[15] = mk(0, 1, 3, 16'h000E, 0, 1, 4, 16'h000F, 0,  0, 1, 1, 7, 16'h000B, 8'h86, 3'b001);
        tbl[16] = mk(0, 0, 0, 16'h0000, 0, 1, 4, 16'h000F, 0,  1, 1, 1, 1, 16'h000C, 8'h0E, 3'b001);
        tbl[17] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 2, 16'h000D, 8'h1C, 3'b001);
        tbl[18] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 3, 16'h000E, 8'h18, 3'b001);
        tbl[19] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 1, 4, 16'h000F, 8'h10, 3'b001);
        tbl[20] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[21] = mk(0, 1, 1, 16'h0100, 1, 1, 2, 16'h0200, 1,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b001);
        tbl[22] = mk(0, 1, 3, 16'h0300, 1, 1, 4, 16'h0400, 1,  1, 1, 1, 1, 16'h0100, 8'h06, 3'b001);
        tbl[23] = mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 0, 16'h0000, 8'h1C, 3'b001);
        tbl[24] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 0, 16'h0000, 8'h00, 3'b010);

        rst = 1'b1;
        mem_valid = 0; mem_dr = 0; mem_data = 0; mem_set_cc = 0;
        ex_valid  = 0; ex_dr  = 0; ex_data  = 0; ex_set_cc  = 0;
        mcc = 3'b010;
        #1;
        tick();
        tick();

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            if (i == 23) wr_snap = wr_cnt;
            @(negedge clk);
            chk($sformatf("v%0d ex_ready", i), ex_ready, tbl[i].x_exr);
            chk($sformatf("v%0d mem_ready", i), mem_ready, tbl[i].x_memr);
            chk($sformatf("v%0d rf_we", i), rf_we, tbl[i].x_we);
            if (tbl[i].x_we) begin
                chk($sformatf("v%0d rf_dr", i), rf_dr, tbl[i].x_dr);
                chk($sformatf("v%0d rf_data", i), rf_data, tbl[i].x_data);
            end
            chk($sformatf("v%0d pending", i), pending, tbl[i].x_pend);
            chk($sformatf("v%0d cc", i), {cc_n, cc_z, cc_p}, tbl[i].x_cc);
            tick();
            if (i == 12) begin
                chk("R5 last value", shadow[5], 16'h2222);
                chk("R3 value", shadow[3], 16'h0005);
                chk("R6 value", shadow[6], 16'hFFFF);
            end
        end
        chk("writes across reset", wr_cnt - wr_snap, 0);

        // Randomized traffic with occasional resets; payload held while stalled.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!(mem_valid && !last_memr)) begin
                mem_valid  = ($urandom_range(0, 2) != 0);
                mem_dr     = 3'($urandom_range(0, 7));
                mem_data   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
                mem_set_cc = 1'($urandom);
            end
            if (!(ex_valid && !last_exr)) begin
                ex_valid  = ($urandom_range(0, 2) != 0);
                ex_dr     = 3'($urandom_range(0, 7));
                ex_data   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                ex_set_cc = 1'($urandom);
            end
            @(negedge clk);
            check_model($sformatf("r%0d", c));
            tick();
        end

        rst = 1'b0; mem_valid = 1'b0; ex_valid = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            @(negedge clk);
            check_model($sformatf("drain%0d", c));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
